// File: rtl/vga_tile_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_tile_arbiter_if
//   Bus bundle between the two tile-RAM requesters, the arbiter and the
//   single-port board RAM (4x4 tiles of the 2048 game).
//
//   slave  : arbiter side (receives requests, drives acks / RAM strobes)
//   master : requester + RAM side (drives requests and ram_rdata)
//
//   vblank                 : vertical blanking indicator from the VGA timing
//   disp_req/addr          : display read request
//   disp_ack/rvalid/rdata  : display grant and read return
//   game_req/we/addr/wdata : game engine request (read or write)
//   game_ack/rvalid/rdata  : game grant and read return
//   starve                 : forced game slot armed
//   ram_en/we/addr/wdata   : registered RAM command
//   ram_rdata              : RAM read data, one cycle after a read strobe
// ---------------------------------------------------------------------------
interface vga_tile_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          vblank;

    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_ack;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;

    logic          game_req;
    logic          game_we;
    logic [AW-1:0] game_addr;
    logic [DW-1:0] game_wdata;
    logic          game_ack;
    logic          game_rvalid;
    logic [DW-1:0] game_rdata;

    logic          starve;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vblank,
        input  disp_req, disp_addr,
        output disp_ack, disp_rvalid, disp_rdata,
        input  game_req, game_we, game_addr, game_wdata,
        output game_ack, game_rvalid, game_rdata,
        output starve,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output vblank,
        output disp_req, disp_addr,
        input  disp_ack, disp_rvalid, disp_rdata,
        output game_req, game_we, game_addr, game_wdata,
        input  game_ack, game_rvalid, game_rdata,
        input  starve,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/vga_tile_arbiter.sv
// ---------------------------------------------------------------------------
// vga_tile_arbiter
//   Shares the single-port board RAM between the VGA scan-out reader and the
//   game-logic engine. Display reads have fixed priority; a starvation
//   counter arms a forced game slot after STARVE_LIM consecutive denials.
//
//   Optional feature macro: TILE_ARB_TEARFREE_EN
//     defined   : game writes are only eligible while vblank = 1
//     undefined : vblank is ignored, every game request is eligible
//
//   Ports:
//     clk_20M : pixel clock, all logic on the rising edge
//     rst_n   : asynchronous active-low reset
//     bus     : vga_tile_arbiter_if.slave (requests, acks, read returns,
//               starve flag and registered RAM command)
//
//   Timing: ack in cycle N (combinational), RAM strobe in N+1,
//   rvalid/rdata in N+2.
// ---------------------------------------------------------------------------
module vga_tile_arbiter #(
    parameter int AW         = 4,
    parameter int DW         = 4,
    parameter int STARVE_LIM = 32
) (
    input  logic                clk_20M,
    input  logic                rst_n,
    vga_tile_arbiter_if.slave   bus
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISP,
        ST_GAME
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_GREAD
    } tag_t;

    state_t        r_state;
    state_t        w_state_next;
    tag_t          w_tag;
    tag_t          r_tag;

    logic          w_game_elig;
    logic          w_game_gnt;
    logic          w_disp_gnt;

    logic          r_ram_en;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;

    logic [7:0]    r_starve_cnt;
    logic [7:0]    w_starve_cnt_next;
    logic          r_starve;

    // ---------------------------------------------------------------------
    // Eligibility
    // ---------------------------------------------------------------------
`ifdef TILE_ARB_TEARFREE_EN
    // Writes wait for vertical blanking so a frame never shows a half-moved
    // board; reads are harmless and always allowed.
    assign w_game_elig = bus.game_req & (~bus.game_we | bus.vblank);
`else
    logic w_unused_vblank;
    assign w_unused_vblank = bus.vblank;
    assign w_game_elig     = bus.game_req;
`endif

    // ---------------------------------------------------------------------
    // Grant: starve-armed game > display > game. Gated by rst_n so the
    // combinational acks are also 0 while reset is held.
    // ---------------------------------------------------------------------
    assign w_game_gnt = rst_n & w_game_elig & (r_starve | ~bus.disp_req);
    assign w_disp_gnt = rst_n & bus.disp_req & ~w_game_gnt;

    assign bus.disp_ack = w_disp_gnt;
    assign bus.game_ack = w_game_gnt;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_20M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state = who was granted this cycle
    always_comb begin
        w_state_next = ST_IDLE;
        if (w_game_gnt) begin
            w_state_next = ST_GAME;
        end else if (w_disp_gnt) begin
            w_state_next = ST_DISP;
        end
    end

    // FSM: output decode. The state marks the access currently on the RAM
    // port; game writes are filtered out so they never raise rvalid.
    always_comb begin
        w_tag = TAG_NONE;
        case (r_state)
            ST_DISP: w_tag = TAG_DISP;
            ST_GAME: w_tag = r_ram_we ? TAG_NONE : TAG_GREAD;
            default: w_tag = TAG_NONE;
        endcase
    end

    // Second owner stage lines up with ram_rdata
    always_ff @(posedge clk_20M or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= TAG_NONE;
        end else begin
            r_tag <= w_tag;
        end
    end

    // ---------------------------------------------------------------------
    // RAM command register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_20M or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_disp_gnt) begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= bus.disp_addr;
        end else if (w_game_gnt) begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= bus.game_we;
            r_ram_addr <= bus.game_addr;
            if (bus.game_we) begin
                r_ram_wdata <= bus.game_wdata;
            end
        end else begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Starvation guard
    // ---------------------------------------------------------------------
    always_comb begin
        w_starve_cnt_next = r_starve_cnt;
        if (!bus.game_req || w_game_gnt) begin
            w_starve_cnt_next = '0;
        end else if (w_game_elig && (r_starve_cnt != LIM)) begin
            w_starve_cnt_next = r_starve_cnt + 8'd1;
        end
    end

    // starve is registered from the next count so it rises the cycle after
    // the counter reaches the limit and drops the cycle after a forced grant.
    always_ff @(posedge clk_20M or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_next;
            r_starve     <= (w_starve_cnt_next == LIM);
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.starve      = r_starve;
    assign bus.ram_en      = r_ram_en;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;

    assign bus.disp_rvalid = (r_tag == TAG_DISP);
    assign bus.game_rvalid = (r_tag == TAG_GREAD);

    // Read data is qualified by its rvalid so both buses sit at 0 otherwise
    assign bus.disp_rdata  = bus.disp_rvalid ? bus.ram_rdata : '0;
    assign bus.game_rdata  = bus.game_rvalid ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_vga_tile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_tile_arbiter
//   Directed bench for vga_tile_arbiter with a behavioural 16x4 board RAM.
//   Inputs are driven on the falling clock edge and outputs checked 1 ns
//   later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_vga_tile_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [3:0] mem [16];

    vga_tile_arbiter_if #(.AW(4), .DW(4)) bus ();

    vga_tile_arbiter #(
        .AW         (4),
        .DW         (4),
        .STARVE_LIM (32)
    ) dut (
        .clk_20M (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model
    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        bus.disp_req = 1'b1; bus.disp_addr = 4'd5;
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 4'd2;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus.disp_ack !== 1'b0) $display("FAIL rst_disp_ack: got %b want 0", bus.disp_ack); else n_pass++;
        n_checks++; if (bus.game_ack !== 1'b0) $display("FAIL rst_game_ack: got %b want 0", bus.game_ack); else n_pass++;
        n_checks++; if (bus.ram_en !== 1'b0) $display("FAIL rst_ram_en: got %b want 0", bus.ram_en); else n_pass++;
        n_checks++; if (bus.ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); else n_pass++;
        n_checks++; if (bus.ram_addr !== 4'd0) $display("FAIL rst_ram_addr: got %h want 0", bus.ram_addr); else n_pass++;
        n_checks++; if (bus.ram_wdata !== 4'd0) $display("FAIL rst_ram_wdata: got %h want 0", bus.ram_wdata); else n_pass++;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL rst_disp_rvalid: got %b want 0", bus.disp_rvalid); else n_pass++;
        n_checks++; if (bus.game_rvalid !== 1'b0) $display("FAIL rst_game_rvalid: got %b want 0", bus.game_rvalid); else n_pass++;
        n_checks++; if (bus.starve !== 1'b0) $display("FAIL rst_starve: got %b want 0", bus.starve); else n_pass++;
        n_checks++; if (bus.disp_rdata !== 4'd0) $display("FAIL rst_disp_rdata: got %h want 0", bus.disp_rdata); else n_pass++;
        // first cycle after release: display wins the tie
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (bus.disp_ack !== 1'b1) $display("FAIL rel_disp_ack: got %b want 1", bus.disp_ack); else n_pass++;
        n_checks++; if (bus.game_ack !== 1'b0) $display("FAIL rel_game_ack: got %b want 0", bus.game_ack); else n_pass++;
        @(negedge clk); bus.disp_req = 1'b0; #1;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL rel_game_ack2: got %b want 1", bus.game_ack); else n_pass++;
        n_checks++; if (bus.ram_en !== 1'b1) $display("FAIL rel_ram_en: got %b want 1", bus.ram_en); else n_pass++;
        n_checks++; if (bus.ram_addr !== 4'd5) $display("FAIL rel_ram_addr: got %h want 5", bus.ram_addr); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0; #1;
        n_checks++; if (bus.disp_rvalid !== 1'b1) $display("FAIL rel_disp_rvalid: got %b want 1", bus.disp_rvalid); else n_pass++;
        n_checks++; if (bus.disp_rdata !== 4'hA) $display("FAIL rel_disp_rdata: got %h want a", bus.disp_rdata); else n_pass++;
        n_checks++; if (bus.ram_addr !== 4'd2) $display("FAIL rel_ram_addr2: got %h want 2", bus.ram_addr); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus.game_rvalid !== 1'b1) $display("FAIL rel_game_rvalid: got %b want 1", bus.game_rvalid); else n_pass++;
        n_checks++; if (bus.game_rdata !== 4'hD) $display("FAIL rel_game_rdata: got %h want d", bus.game_rdata); else n_pass++;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL rel_disp_rvalid2: got %b want 0", bus.disp_rvalid); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_disp_read;
        @(negedge clk); bus.disp_req = 1'b1; bus.disp_addr = 4'd5; #1;
        n_checks++; if (bus.disp_ack !== 1'b1) $display("FAIL dr_ack: got %b want 1", bus.disp_ack); else n_pass++;
        @(negedge clk); bus.disp_req = 1'b0; #1;
        n_checks++; if (bus.ram_en !== 1'b1) $display("FAIL dr_ram_en: got %b want 1", bus.ram_en); else n_pass++;
        n_checks++; if (bus.ram_we !== 1'b0) $display("FAIL dr_ram_we: got %b want 0", bus.ram_we); else n_pass++;
        n_checks++; if (bus.ram_addr !== 4'd5) $display("FAIL dr_ram_addr: got %h want 5", bus.ram_addr); else n_pass++;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL dr_early_rvalid: got %b want 0", bus.disp_rvalid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus.disp_rvalid !== 1'b1) $display("FAIL dr_rvalid: got %b want 1", bus.disp_rvalid); else n_pass++;
        n_checks++; if (bus.disp_rdata !== 4'hA) $display("FAIL dr_rdata: got %h want a", bus.disp_rdata); else n_pass++;
        n_checks++; if (bus.ram_en !== 1'b0) $display("FAIL dr_ram_en_off: got %b want 0", bus.ram_en); else n_pass++;
        n_checks++; if (bus.ram_addr !== 4'd5) $display("FAIL dr_addr_hold: got %h want 5", bus.ram_addr); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL dr_rvalid_once: got %b want 0", bus.disp_rvalid); else n_pass++;
    endtask

    task automatic test_game_write_read;
        @(negedge clk); bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 4'd3; bus.game_wdata = 4'h7; #1;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL gw_ack: got %b want 1", bus.game_ack); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0; #1;
        n_checks++; if (bus.ram_en !== 1'b1) $display("FAIL gw_ram_en: got %b want 1", bus.ram_en); else n_pass++;
        n_checks++; if (bus.ram_we !== 1'b1) $display("FAIL gw_ram_we: got %b want 1", bus.ram_we); else n_pass++;
        n_checks++; if (bus.ram_addr !== 4'd3) $display("FAIL gw_ram_addr: got %h want 3", bus.ram_addr); else n_pass++;
        n_checks++; if (bus.ram_wdata !== 4'h7) $display("FAIL gw_ram_wdata: got %h want 7", bus.ram_wdata); else n_pass++;
        @(negedge clk); bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 4'd3; #1;
        n_checks++; if (bus.game_rvalid !== 1'b0) $display("FAIL gw_no_rvalid: got %b want 0", bus.game_rvalid); else n_pass++;
        n_checks++; if (bus.ram_we !== 1'b0) $display("FAIL gw_we_clear: got %b want 0", bus.ram_we); else n_pass++;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL gr_ack: got %b want 1", bus.game_ack); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0; #1;
        n_checks++; if (bus.game_rvalid !== 1'b0) $display("FAIL gr_early_rvalid: got %b want 0", bus.game_rvalid); else n_pass++;
        n_checks++; if (bus.ram_we !== 1'b0) $display("FAIL gr_ram_we: got %b want 0", bus.ram_we); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus.game_rvalid !== 1'b1) $display("FAIL gr_rvalid: got %b want 1", bus.game_rvalid); else n_pass++;
        n_checks++; if (bus.game_rdata !== 4'h7) $display("FAIL gr_rdata: got %h want 7", bus.game_rdata); else n_pass++;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL gr_disp_rvalid: got %b want 0", bus.disp_rvalid); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_starvation;
        @(negedge clk);
        bus.disp_req = 1'b1; bus.disp_addr = 4'd0;
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 4'd3;
        for (int i = 0; i < 32; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            n_checks++; if (bus.disp_ack !== 1'b1) $display("FAIL sv_disp_ack[%0d]: got %b want 1", i, bus.disp_ack); else n_pass++;
            n_checks++; if (bus.game_ack !== 1'b0) $display("FAIL sv_game_deny[%0d]: got %b want 0", i, bus.game_ack); else n_pass++;
            n_checks++; if (bus.starve !== 1'b0) $display("FAIL sv_starve_low[%0d]: got %b want 0", i, bus.starve); else n_pass++;
        end
        @(negedge clk); #1;
        n_checks++; if (bus.starve !== 1'b1) $display("FAIL sv_starve: got %b want 1", bus.starve); else n_pass++;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL sv_forced_ack: got %b want 1", bus.game_ack); else n_pass++;
        n_checks++; if (bus.disp_ack !== 1'b0) $display("FAIL sv_disp_held: got %b want 0", bus.disp_ack); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0; #1;
        n_checks++; if (bus.starve !== 1'b0) $display("FAIL sv_starve_fall: got %b want 0", bus.starve); else n_pass++;
        n_checks++; if (bus.disp_ack !== 1'b1) $display("FAIL sv_disp_resume: got %b want 1", bus.disp_ack); else n_pass++;
        n_checks++; if (bus.disp_rvalid !== 1'b1) $display("FAIL sv_disp_rvalid: got %b want 1", bus.disp_rvalid); else n_pass++;
        n_checks++; if (bus.disp_rdata !== 4'hF) $display("FAIL sv_disp_rdata: got %h want f", bus.disp_rdata); else n_pass++;
        @(negedge clk); bus.disp_req = 1'b0; #1;
        n_checks++; if (bus.game_rvalid !== 1'b1) $display("FAIL sv_game_rvalid: got %b want 1", bus.game_rvalid); else n_pass++;
        n_checks++; if (bus.game_rdata !== 4'h7) $display("FAIL sv_game_rdata: got %h want 7", bus.game_rdata); else n_pass++;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL sv_disp_gap: got %b want 0", bus.disp_rvalid); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

`ifdef TILE_ARB_TEARFREE_EN
    task automatic test_tearfree;
        @(negedge clk);
        bus.vblank = 1'b0;
        bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 4'd9; bus.game_wdata = 4'h3;
        for (int i = 0; i < 100; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            n_checks++; if (bus.game_ack !== 1'b0) $display("FAIL tf_blocked[%0d]: got %b want 0", i, bus.game_ack); else n_pass++;
            n_checks++; if (bus.starve !== 1'b0) $display("FAIL tf_starve[%0d]: got %b want 0", i, bus.starve); else n_pass++;
        end
        @(negedge clk); bus.vblank = 1'b1; #1;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL tf_vblank_ack: got %b want 1", bus.game_ack); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0; bus.vblank = 1'b0; #1;
        n_checks++; if (bus.ram_we !== 1'b1) $display("FAIL tf_ram_we: got %b want 1", bus.ram_we); else n_pass++;
        n_checks++; if (bus.ram_addr !== 4'd9) $display("FAIL tf_ram_addr: got %h want 9", bus.ram_addr); else n_pass++;
        n_checks++; if (bus.ram_wdata !== 4'h3) $display("FAIL tf_ram_wdata: got %h want 3", bus.ram_wdata); else n_pass++;
        // reads stay eligible outside blanking
        @(negedge clk); bus.game_req = 1'b1; bus.game_we = 1'b0; #1;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL tf_read_ack: got %b want 1", bus.game_ack); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (bus.game_rvalid !== 1'b1) $display("FAIL tf_rvalid: got %b want 1", bus.game_rvalid); else n_pass++;
        n_checks++; if (bus.game_rdata !== 4'h3) $display("FAIL tf_rdata: got %h want 3", bus.game_rdata); else n_pass++;
        @(negedge clk);
    endtask
`else
    task automatic test_vblank_ignored;
        @(negedge clk);
        bus.vblank = 1'b0;
        bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 4'd9; bus.game_wdata = 4'h3; #1;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL vi_write_ack: got %b want 1", bus.game_ack); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0; #1;
        n_checks++; if (bus.ram_we !== 1'b1) $display("FAIL vi_ram_we: got %b want 1", bus.ram_we); else n_pass++;
        n_checks++; if (bus.ram_addr !== 4'd9) $display("FAIL vi_ram_addr: got %h want 9", bus.ram_addr); else n_pass++;
        n_checks++; if (bus.ram_wdata !== 4'h3) $display("FAIL vi_ram_wdata: got %h want 3", bus.ram_wdata); else n_pass++;
        @(negedge clk); bus.game_req = 1'b1; bus.game_we = 1'b0; #1;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL vi_read_ack: got %b want 1", bus.game_ack); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (bus.game_rvalid !== 1'b1) $display("FAIL vi_rvalid: got %b want 1", bus.game_rvalid); else n_pass++;
        n_checks++; if (bus.game_rdata !== 4'h3) $display("FAIL vi_rdata: got %h want 3", bus.game_rdata); else n_pass++;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_midop;
        @(negedge clk);
        bus.disp_req = 1'b1; bus.disp_addr = 4'd5;
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 4'd2; #1;
        n_checks++; if (bus.disp_ack !== 1'b1) $display("FAIL rm_pre_ack: got %b want 1", bus.disp_ack); else n_pass++;
        repeat (9) @(negedge clk);
        // one cycle after the last display ack
        @(negedge clk); rst_n = 1'b0; #1;
        n_checks++; if (bus.ram_en !== 1'b0) $display("FAIL rm_ram_en: got %b want 0", bus.ram_en); else n_pass++;
        n_checks++; if (bus.disp_ack !== 1'b0) $display("FAIL rm_disp_ack: got %b want 0", bus.disp_ack); else n_pass++;
        n_checks++; if (bus.game_ack !== 1'b0) $display("FAIL rm_game_ack: got %b want 0", bus.game_ack); else n_pass++;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL rm_rvalid_in_rst: got %b want 0", bus.disp_rvalid); else n_pass++;
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (bus.disp_ack !== 1'b1) $display("FAIL rm_first_ack: got %b want 1", bus.disp_ack); else n_pass++;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL rm_rvalid0: got %b want 0", bus.disp_rvalid); else n_pass++;
        n_checks++; if (bus.game_rvalid !== 1'b0) $display("FAIL rm_grvalid0: got %b want 0", bus.game_rvalid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus.disp_rvalid !== 1'b0) $display("FAIL rm_rvalid1: got %b want 0", bus.disp_rvalid); else n_pass++;
        n_checks++; if (bus.game_ack !== 1'b0) $display("FAIL rm_deny1: got %b want 0", bus.game_ack); else n_pass++;
        // counter restarted at 0: game still denied through the 32nd cycle
        for (int i = 2; i < 32; i++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.game_ack !== 1'b0) $display("FAIL rm_deny[%0d]: got %b want 0", i, bus.game_ack); else n_pass++;
        end
        @(negedge clk); #1;
        n_checks++; if (bus.starve !== 1'b1) $display("FAIL rm_starve: got %b want 1", bus.starve); else n_pass++;
        n_checks++; if (bus.game_ack !== 1'b1) $display("FAIL rm_forced_ack: got %b want 1", bus.game_ack); else n_pass++;
        @(negedge clk); bus.game_req = 1'b0; bus.disp_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        bus.vblank     = 1'b0;
        bus.disp_req   = 1'b0;
        bus.disp_addr  = '0;
        bus.game_req   = 1'b0;
        bus.game_we    = 1'b0;
        bus.game_addr  = '0;
        bus.game_wdata = '0;
        bus.ram_rdata  = '0;
        #1 rst_n = 1'b0;

        test_reset();
        test_disp_read();
        test_game_write_read();
        test_starvation();
`ifdef TILE_ARB_TEARFREE_EN
        test_tearfree();
`else
        test_vblank_ignored();
`endif
        test_reset_midop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
